// File: rtl/hqm_list_sel_rf_64x8_ctl.sv
// hqm_list_sel_rf_64x8_ctl
//   Access controller in front of the 64x8 list-select register file.
//   After reset it writes zero to every entry. It then accepts independent
//   write and read requests and drives the RF ports. A read that collides
//   with a same-cycle write returns the write data. Read responses come back
//   through a small FIFO that the consumer can stall.
//
// State table
//   state   | meaning
//   ST_INIT | zero-fill the RF one entry per cycle; both request readies low
//   ST_RUN  | normal operation; write pass-through, credited reads
//
// Ports
//   clk, rst                       clock, async active-high reset
//   wr_req_valid/ready/addr/data   write request channel
//   rd_req_valid/ready/addr        read request channel
//   rd_rsp_valid/ready/data        read response channel (head of FIFO)
//   init_done                      zero-fill has completed
//   rf_we/waddr/wdata              RF write port
//   rf_re/raddr/rdata              RF read port, rdata valid RD_LAT cycles after rf_re
module hqm_list_sel_rf_64x8_ctl #(
    parameter int DEPTH      = 64,
    parameter int DWIDTH     = 8,
    parameter int RD_LAT     = 1,
    parameter int OBUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [5:0]        wr_req_addr,
    input  logic [DWIDTH-1:0] wr_req_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [5:0]        rd_req_addr,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [DWIDTH-1:0] rd_rsp_data,
    output logic              init_done,
    output logic              rf_we,
    output logic [5:0]        rf_waddr,
    output logic [DWIDTH-1:0] rf_wdata,
    output logic              rf_re,
    output logic [5:0]        rf_raddr,
    input  logic [DWIDTH-1:0] rf_rdata
);

    localparam int         PW        = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int         CW        = $clog2(OBUF_DEPTH + 1);
    localparam int         OW        = $clog2(OBUF_DEPTH + RD_LAT + 1) + 1;
    localparam logic [5:0] LAST_ADDR = 6'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [5:0]        init_cnt_q;

    logic [RD_LAT-1:0] infl_q;
    logic [RD_LAT-1:0] byp_q;
    logic [DWIDTH-1:0] byp_data_q [RD_LAT];

    logic [DWIDTH-1:0] obuf_q [OBUF_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;

    logic              rd_issue;
    logic              collide;
    logic              push, pop;
    logic [DWIDTH-1:0] push_data;
    logic [OW-1:0]     infl_cnt;
    logic [OW-1:0]     occ_net;
    logic              credit_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_cnt_q == LAST_ADDR) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // rf_we is gated by rst so the array sees no write while reset is held.
    always_comb begin
        wr_req_ready = 1'b0;
        rd_req_ready = 1'b0;
        init_done    = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = init_cnt_q;
        rf_wdata     = '0;
        case (state_q)
            ST_INIT: begin
                rf_we = !rst;
            end
            ST_RUN: begin
                init_done    = 1'b1;
                wr_req_ready = 1'b1;
                rd_req_ready = credit_ok;
                rf_we        = wr_req_valid;
                rf_waddr     = wr_req_addr;
                rf_wdata     = wr_req_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + 1'b1;
        end
    end

    // ---------------- read issue and in-flight tracking ----------------
    assign rd_issue = rd_req_valid && rd_req_ready;
    assign rf_re    = rd_issue;
    assign rf_raddr = rd_req_addr;
    // wr_req_ready is high whenever a read can issue, so a valid write here is accepted.
    assign collide  = wr_req_valid && (wr_req_addr == rd_req_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_q <= '0;
            byp_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) byp_data_q[i] <= '0;
        end else begin
            infl_q[0]     <= rd_issue;
            byp_q[0]      <= rd_issue && collide;
            byp_data_q[0] <= wr_req_data;
            for (int i = 1; i < RD_LAT; i++) begin
                infl_q[i]     <= infl_q[i-1];
                byp_q[i]      <= byp_q[i-1];
                byp_data_q[i] <= byp_data_q[i-1];
            end
        end
    end

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) infl_cnt = infl_cnt + OW'(infl_q[i]);
    end

    // Credit counts buffered plus in-flight responses, freeing the slot that
    // leaves this cycle so streaming reads sustain one per cycle.
    assign occ_net   = OW'(cnt_q) + infl_cnt - OW'(pop);
    assign credit_ok = (occ_net < OW'(OBUF_DEPTH));

    // ---------------- output response FIFO ----------------
    assign push      = infl_q[RD_LAT-1];
    assign push_data = byp_q[RD_LAT-1] ? byp_data_q[RD_LAT-1] : rf_rdata;
    assign pop       = rd_rsp_valid && rd_rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OBUF_DEPTH; i++) obuf_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                obuf_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    assign rd_rsp_valid = (cnt_q != '0);
    assign rd_rsp_data  = obuf_q[rd_ptr_q];

endmodule

// File: tb/tb_hqm_list_sel_rf_64x8_ctl.sv
// Bench for hqm_list_sel_rf_64x8_ctl: behavioural RF model, shadow-memory
// scoreboard, table of single-transaction vectors and hand-written sequences
// for init, backpressure, streaming and mid-operation reset.
module tb_hqm_list_sel_rf_64x8_ctl;

    logic       clk;
    logic       rst;
    logic       wr_req_valid, wr_req_ready;
    logic [5:0] wr_req_addr;
    logic [7:0] wr_req_data;
    logic       rd_req_valid, rd_req_ready;
    logic [5:0] rd_req_addr;
    logic       rd_rsp_valid, rd_rsp_ready;
    logic [7:0] rd_rsp_data;
    logic       init_done;
    logic       rf_we, rf_re;
    logic [5:0] rf_waddr, rf_raddr;
    logic [7:0] rf_wdata, rf_rdata;

    hqm_list_sel_rf_64x8_ctl dut (
        .clk(clk), .rst(rst),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_rsp_data(rd_rsp_data), .init_done(init_done),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: one-cycle read latency, read returns old contents.
    logic [7:0] rf_mem [64];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        if (rf_re) rf_rdata <= rf_mem[rf_raddr];
    end

    int         n_total = 0;
    int         n_pass  = 0;
    logic [7:0] shadow [64];
    logic [7:0] sb [$];
    logic       pop_seen;
    logic       last_racc;
    logic [7:0] last_pop;

    typedef struct {
        logic       wr_en;
        logic [5:0] waddr;
        logic [7:0] wdata;
        logic       rd_en;
        logic [5:0] raddr;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
    endtask

    // One cycle: sample 2 time units after the falling edge, update the
    // scoreboard, then advance to the next falling edge.
    task automatic step();
        logic       wacc, racc, pop;
        logic [7:0] e;
        #2;
        wacc      = wr_req_valid && wr_req_ready;
        racc      = rd_req_valid && rd_req_ready;
        pop       = rd_rsp_valid && rd_rsp_ready;
        pop_seen  = pop;
        last_racc = racc;
        if (pop) begin
            last_pop = rd_rsp_data;
            if (sb.size() == 0) chk("sb_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("sb_rsp_data", rd_rsp_data, e);
            end
        end
        if (rd_req_valid && init_done) chk("rf_re_match", rf_re, racc);
        if (racc) begin
            chk("rf_raddr", rf_raddr, rd_req_addr);
            e = (wacc && wr_req_addr == rd_req_addr) ? wr_req_data : shadow[rd_req_addr];
            sb.push_back(e);
        end
        if (wacc) begin
            chk("rf_write_pass", {rf_we, rf_waddr, rf_wdata}, {1'b1, wr_req_addr, wr_req_data});
            shadow[wr_req_addr] = wr_req_data;
        end
        @(negedge clk);
    endtask

    // Expects to be called at the falling edge where rst has just dropped.
    task automatic check_init();
        for (int i = 0; i < 64; i++) begin
            #2;
            chk("init_cycle", {rf_we, rf_waddr, rf_wdata, wr_req_ready, rd_req_ready, init_done},
                {1'b1, 6'(i), 8'h00, 1'b0, 1'b0, 1'b0});
            @(negedge clk);
        end
        #2;
        chk("init_done_after", {init_done, rf_we, wr_req_ready, rd_req_ready}, 4'b1011);
        @(negedge clk);
    endtask

    task automatic wait_pop(input string name, input logic [7:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        pop_seen = 1'b0;
        while (!pop_seen && lat < 6) begin
            step();
            lat++;
        end
        if (!pop_seen) chk({name, "_timeout"}, 32'd0, 32'd1);
        else begin
            chk({name, "_data"}, last_pop, exp);
            chk({name, "_latency"}, lat, exp_lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc, pops, first_pop, last_pop_idx, sidx, k;
        logic [7:0] held;

        vecs[0] = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd5,  8'h00};
        vecs[1] = '{1'b1, 6'd9,  8'hA5, 1'b1, 6'd9,  8'hA5};
        vecs[2] = '{1'b1, 6'd9,  8'h3C, 1'b0, 6'd0,  8'h00};
        vecs[3] = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd9,  8'h3C};
        vecs[4] = '{1'b1, 6'd20, 8'h77, 1'b1, 6'd21, 8'h00};
        vecs[5] = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd20, 8'h77};
        vecs[6] = '{1'b1, 6'd63, 8'hFF, 1'b1, 6'd63, 8'hFF};
        vecs[7] = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd63, 8'hFF};
        vecs[8] = '{1'b1, 6'd0,  8'h11, 1'b1, 6'd0,  8'h11};
        vecs[9] = '{1'b1, 6'd0,  8'h22, 1'b1, 6'd0,  8'h22};

        for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
        rst = 1'b1;
        idle_inputs();
        wr_req_addr  = '0;
        wr_req_data  = '0;
        rd_req_addr  = '0;
        rd_rsp_ready = 1'b1;

        #2;
        chk("reset_state", {rd_rsp_valid, rd_rsp_data, init_done, rf_we, rf_re}, 12'h000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_init();

        // Table-driven single transactions.
        for (int v = 0; v < 10; v++) begin
            wr_req_valid = vecs[v].wr_en;
            wr_req_addr  = vecs[v].waddr;
            wr_req_data  = vecs[v].wdata;
            rd_req_valid = vecs[v].rd_en;
            rd_req_addr  = vecs[v].raddr;
            step();
            if (vecs[v].rd_en) chk("vec_rd_accept", last_racc, 1'b1);
            idle_inputs();
            if (vecs[v].rd_en) wait_pop("vec_rsp", vecs[v].exp, 2);
        end

        // Read 9 then write 9 the next cycle: the issued read keeps the old value.
        rd_req_valid = 1'b1; rd_req_addr = 6'd9;
        step();
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b1; wr_req_addr = 6'd9; wr_req_data = 8'h55;
        pop_seen = 1'b0;
        step();
        wr_req_valid = 1'b0;
        wait_pop("late_write", 8'h3C, 1);
        rd_req_valid = 1'b1; rd_req_addr = 6'd9;
        step();
        rd_req_valid = 1'b0;
        wait_pop("after_late_write", 8'h55, 2);

        // Preload 0..15 with addr*3, then stream reads.
        for (int i = 0; i < 16; i++) begin
            wr_req_valid = 1'b1; wr_req_addr = 6'(i); wr_req_data = 8'(i * 3);
            step();
        end
        wr_req_valid = 1'b0;
        pops = 0; first_pop = -1; last_pop_idx = -1; sidx = 0; acc = 0;
        for (int s = 0; s < 22; s++) begin
            if (s < 16) begin
                rd_req_valid = 1'b1; rd_req_addr = 6'(s);
            end else rd_req_valid = 1'b0;
            step();
            if (s < 16 && last_racc) acc++;
            if (pop_seen) begin
                chk("stream_data", last_pop, 8'(sidx * 3));
                sidx++;
                pops++;
                if (first_pop < 0) first_pop = s;
                last_pop_idx = s;
            end
        end
        chk("stream_accepts", acc, 16);
        chk("stream_pops", pops, 16);
        chk("stream_consecutive", last_pop_idx - first_pop, 15);

        // Backpressure: consumer stalled, reads offered every cycle.
        rd_rsp_ready = 1'b0;
        acc = 0; k = 1;
        held = 8'h00;
        for (int s = 0; s < 6; s++) begin
            rd_req_valid = 1'b1; rd_req_addr = 6'(k);
            step();
            if (last_racc) begin acc++; k++; end
            if (s == 2) held = rd_rsp_data;
            if (s > 2) chk("stall_hold", {rd_rsp_valid, rd_rsp_data}, {1'b1, held});
        end
        chk("stall_accepts", acc, 2);
        chk("stall_held_value", held, 8'h03);
        #2;
        chk("stall_rd_ready", rd_req_ready, 1'b0);
        @(negedge clk);
        rd_req_valid = 1'b0;
        rd_rsp_ready = 1'b1;
        pops = 0;
        for (int s = 0; s < 5; s++) begin
            step();
            if (pop_seen) pops++;
        end
        chk("drain_pops", pops, 2);
        chk("drain_sb_empty", sb.size(), 0);
        rd_req_valid = 1'b1; rd_req_addr = 6'd4;
        step();
        chk("ready_recovered", last_racc, 1'b1);
        rd_req_valid = 1'b0;
        wait_pop("recover_rsp", 8'h0C, 2);

        // Reset with one response buffered and one in flight.
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 6'd2;
        step();
        rd_req_addr = 6'd3;
        step();
        chk("pre_reset_accept", last_racc, 1'b1);
        rd_req_valid = 1'b0;
        #2;
        chk("pre_reset_valid", rd_rsp_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("reset_mid_outputs", {rd_rsp_valid, init_done, rf_we, rf_re}, 4'b0000);
        sb.delete();
        for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
        @(negedge clk);
        #2;
        chk("reset_hold_no_write", rf_we, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        rd_rsp_ready = 1'b1;
        check_init();
        pops = 0;
        for (int s = 0; s < 8; s++) begin
            step();
            if (pop_seen) pops++;
        end
        chk("no_stale_rsp", pops, 0);
        rd_req_valid = 1'b1; rd_req_addr = 6'd9;
        step();
        rd_req_valid = 1'b0;
        wait_pop("post_reset_read", 8'h00, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
